uart_rx_frame_checker: RTL
==========================

// Module: uart_rx_frame_checker
// PURPOSE
//  Clocked, parametrised frame checker for the UART receive path. It sits between the RX bit
//  sampler and the host-side consumer, and validates each captured frame: start, stop, parity
//  and break. It queues {flags, data} in a small FIFO with a valid/ready handshake, and keeps
//  sticky error status plus saturating statistics counters.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame; legal range 5..9
//  STOP_BITS   1  stop bits checked per frame; 1 or 2
//  FIFO_DEPTH  4  result queue entries; power of two, >= 2
//  CNT_WIDTH   16 width of each statistics counter
// PORTS
//  clock        in   1           system clock, rising edge
//  reset        in   1           asynchronous, active-high; clears all state
//  frame_valid  in   1           1-cycle strobe: the frame fields below are valid this cycle
//  start_bit    in   1           sampled start bit; expected 0
//  stop_bits    in   STOP_BITS   sampled stop bits; expected all 1
//  parity_bit   in   1           sampled parity bit; ignored when parity is disabled
//  parity_type  in   2           00 none, 01 odd, 10 even, 11 none
//  raw_data     in   DATA_WIDTH  sampled data bits, LSB first on the line
//  out_valid    out  1           FIFO head holds a result
//  out_ready    in   1           consumer accepts the head this cycle
//  out_data     out  DATA_WIDTH  data of the head entry
//  out_error    out  3           head flags: [0] parity, [1] start, [2] stop
//  out_break    out  1           head entry is a break condition
//  overrun      out  1           sticky: a frame was dropped because the FIFO was full
//  err_sticky   out  3           sticky OR of all out_error values pushed since the last clear
//  clear_stats  in   1           synchronous clear of all counters and sticky bits
//  frame_cnt    out  CNT_WIDTH   frames pushed, saturating
//  error_cnt    out  CNT_WIDTH   frames pushed with any out_error bit set, saturating
//  drop_cnt     out  CNT_WIDTH   frames dropped on overrun, saturating
// BEHAVIOUR
//  - Reset: FIFO empty. out_valid=0; out_data, out_error and out_break = 0. overrun=0,
//    err_sticky=0, all counters 0. Asserting reset mid-transfer discards queued entries.
//  - Checks are combinational on the frame_valid cycle:
//    - parity error: parity_type 01 and ^raw_data==parity_bit; or parity_type 10 and
//      ^raw_data!=parity_bit; otherwise 0.
//    - start error: start_bit==1.
//    - stop error: any stop_bits bit == 0.
//    - break: start_bit==0, raw_data==0 and all stop_bits==0. When break is set, the stop
//      and parity flags are forced to 0.
//  - Latency: frame_valid at edge N writes the FIFO. With the FIFO empty, out_valid=1 after
//    edge N. out_* are driven from the FIFO head and stay stable while out_valid && !out_ready.
//  - Pop: out_valid && out_ready at an edge removes the head.
//  - Push when full: if a pop occurs in the same cycle, the push is accepted. Otherwise the
//    frame is dropped, overrun is set and drop_cnt increments.
//  - frame_valid while reset is high: ignored.
//  - Counters: each increments by 1 per qualifying event and holds at all-ones.
//  - clear_stats: takes priority over a same-cycle increment or sticky set. Counters and sticky
//    bits read 0 after the edge. FIFO contents are not touched.
//  - FIFO pointers: log2(FIFO_DEPTH)+1 bits; wrap-around is natural. full/empty are derived
//    from the pointer MSB comparison.
// STRUCTURE
//  - uart_defs.vh: PAR_NONE/PAR_ODD/PAR_EVEN codes; ERR_PARITY/ERR_START/ERR_STOP bit indices
//    shared with the sampler and the TX parity generator.
//  - Sub-module uart_sync_fifo #(WIDTH, DEPTH): width = DATA_WIDTH+4, with full, empty, push
//    and pop ports.
//  - Top level holds the check logic, the counters and the sticky registers.
// TESTING
//  1. reset=1 for 3 cycles, then release -> every output is 0; out_valid=0.
//  2. raw_data=8'h55, parity_type=01, parity_bit=1, start=0, stop=1 -> one cycle later
//     out_valid=1, out_data=8'h55, out_error=000, frame_cnt=1.
//  3. Same frame with parity_type=10, parity_bit=1, start=1, stop=0 -> out_error=111,
//     err_sticky=111, error_cnt=1.
//  4. raw_data=0, start=0, stop=0, parity_type=01, parity_bit=0 -> out_break=1, out_error=000.
//  5. out_ready=0; push 5 frames into FIFO_DEPTH=4 -> 4 entries queued, overrun=1, drop_cnt=1.
//     Then a push and a pop in the same cycle while full -> accepted, drop_cnt stays 1.
//  6. Assert clear_stats in the same cycle as an erroring frame -> counters and err_sticky are 0;
//     the entry is still queued. Assert reset with 3 queued entries -> out_valid=0 immediately.

Source files
------------

// File: rtl/uart_rx_frame_checker_pkg.sv
// Shared parity codes, error-flag bit positions and the result-flag layout used by the
// UART receive path (sampler, frame checker and TX parity generator).
package uart_rx_frame_checker_pkg;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_ODD  = 2'b01;
   localparam logic [1:0] PAR_EVEN = 2'b10;

   localparam int ERR_PARITY = 0;
   localparam int ERR_START  = 1;
   localparam int ERR_STOP   = 2;
   localparam int ERR_W      = 3;

   // Flag bits stored above the data in each queued result.
   typedef struct packed {
      logic             brk;
      logic [ERR_W-1:0] err;
   } flags_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock result queue; pointers carry one extra wrap bit so full/empty come from
// comparing the MSBs. The caller only pushes when not full (or popping) and pops when not empty.
module uart_sync_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   // Masked so an empty queue presents zeros rather than a stale entry.
   assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

   always_comb begin
      wr_d = push_i ? wr_q + PTR_ONE : wr_q;
      rd_d = pop_i  ? rd_q + PTR_ONE : rd_q;
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clock_i) begin
      if (push_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/uart_rx_frame_checker.sv
// Validates each sampled UART frame (start/stop/parity/break), queues {flags, data} for the
// host, and keeps sticky error status plus saturating frame/error/drop counters.
module uart_rx_frame_checker
   import uart_rx_frame_checker_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  frame_valid_i,
   input  logic                  start_bit_i,
   input  logic [STOP_BITS-1:0]  stop_bits_i,
   input  logic                  parity_bit_i,
   input  logic [1:0]            parity_type_i,
   input  logic [DATA_WIDTH-1:0] raw_data_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic [ERR_W-1:0]      out_error_o,
   output logic                  out_break_o,
   output logic                  overrun_o,
   output logic [ERR_W-1:0]      err_sticky_o,
   input  logic                  clear_stats_i,
   output logic [CNT_WIDTH-1:0]  frame_cnt_o,
   output logic [CNT_WIDTH-1:0]  error_cnt_o,
   output logic [CNT_WIDTH-1:0]  drop_cnt_o
);

   localparam int FW = DATA_WIDTH + 1 + ERR_W;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic                  par_err, brk;
   flags_t                flags;
   logic                  fifo_full, fifo_empty;
   logic                  push, pop, drop;
   logic [FW-1:0]         fifo_rdata;
   flags_t                head_flags;

   logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
   logic [CNT_WIDTH-1:0]  error_cnt_q, error_cnt_d;
   logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
   logic [ERR_W-1:0]      err_sticky_q, err_sticky_d;
   logic                  overrun_q, overrun_d;

   always_comb begin
      par_err = 1'b0;
      case (parity_type_i)
         PAR_ODD:  par_err = ((^raw_data_i) == parity_bit_i);
         PAR_EVEN: par_err = ((^raw_data_i) != parity_bit_i);
         default:  par_err = 1'b0;
      endcase
      brk = !start_bit_i && (raw_data_i == '0) && (stop_bits_i == '0);
      // A break looks like a framing/parity failure; only the break flag is meaningful.
      flags.brk             = brk;
      flags.err             = '0;
      flags.err[ERR_PARITY] = par_err && !brk;
      flags.err[ERR_START]  = start_bit_i;
      flags.err[ERR_STOP]   = !(&stop_bits_i) && !brk;
   end

   assign pop  = !fifo_empty && out_ready_i;
   assign push = frame_valid_i && (!fifo_full || pop);
   assign drop = frame_valid_i && fifo_full && !pop;

   uart_sync_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i ({flags, raw_data_i}),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign head_flags  = fifo_rdata[FW-1:DATA_WIDTH];
   assign out_valid_o = !fifo_empty;
   assign out_data_o  = fifo_rdata[DATA_WIDTH-1:0];
   assign out_error_o = head_flags.err;
   assign out_break_o = head_flags.brk;

   always_comb begin
      frame_cnt_d  = frame_cnt_q;
      error_cnt_d  = error_cnt_q;
      drop_cnt_d   = drop_cnt_q;
      err_sticky_d = err_sticky_q;
      overrun_d    = overrun_q;
      if (clear_stats_i) begin
         frame_cnt_d  = '0;
         error_cnt_d  = '0;
         drop_cnt_d   = '0;
         err_sticky_d = '0;
         overrun_d    = 1'b0;
      end else begin
         if (push && (frame_cnt_q != '1)) frame_cnt_d = frame_cnt_q + CNT_ONE;
         if (push && (|flags.err) && (error_cnt_q != '1)) error_cnt_d = error_cnt_q + CNT_ONE;
         if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_ONE;
         if (push) err_sticky_d = err_sticky_q | flags.err;
         if (drop) overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         frame_cnt_q  <= '0;
         error_cnt_q  <= '0;
         drop_cnt_q   <= '0;
         err_sticky_q <= '0;
         overrun_q    <= 1'b0;
      end else begin
         frame_cnt_q  <= frame_cnt_d;
         error_cnt_q  <= error_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
         err_sticky_q <= err_sticky_d;
         overrun_q    <= overrun_d;
      end
   end

   assign frame_cnt_o  = frame_cnt_q;
   assign error_cnt_o  = error_cnt_q;
   assign drop_cnt_o   = drop_cnt_q;
   assign err_sticky_o = err_sticky_q;
   assign overrun_o    = overrun_q;

endmodule
